// File: rtl/axi_r_upsize_packer.sv
// Read-return packer for the data-width downsizer: collects narrow R beats of one
// INCR burst into wide R beats, merging responses and tagging the burst's last beat.
module axi_r_upsize_packer #(
   parameter int unsigned NarrowDataWidth = 32,
   parameter int unsigned WideDataWidth   = 64,
   parameter int unsigned IdWidth         = 4,
   parameter int unsigned UserWidth       = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  cmd_valid_i,
   output logic                                  cmd_ready_o,
   input  logic [IdWidth-1:0]                    cmd_id_i,
   input  logic [$clog2(WideDataWidth/8)-1:0]    cmd_offset_i,
   input  logic [2:0]                            cmd_size_i,
   input  logic [7:0]                            cmd_len_i,
   input  logic [NarrowDataWidth-1:0]            nr_data_i,
   input  logic [1:0]                            nr_resp_i,
   input  logic                                  nr_last_i,
   input  logic [UserWidth-1:0]                  nr_user_i,
   input  logic                                  nr_valid_i,
   output logic                                  nr_ready_o,
   output logic [IdWidth-1:0]                    wr_id_o,
   output logic [WideDataWidth-1:0]              wr_data_o,
   output logic [1:0]                            wr_resp_o,
   output logic                                  wr_last_o,
   output logic [UserWidth-1:0]                  wr_user_o,
   output logic                                  wr_valid_o,
   input  logic                                  wr_ready_i,
   output logic                                  proto_err_o
);

   localparam int unsigned NarrowBytes = NarrowDataWidth / 8;
   localparam int unsigned WideBytes   = WideDataWidth / 8;
   localparam int unsigned AddrWidth   = $clog2(WideBytes);

   typedef enum logic {StIdle, StPack} state_e;

   state_e                     state_q;
   logic [IdWidth-1:0]         id_q;
   logic [AddrWidth-1:0]       addr_q;
   logic [2:0]                 size_q;
   logic [7:0]                 rem_q;
   logic [WideDataWidth-1:0]   acc_data_q;
   logic [1:0]                 acc_err_q;
   logic                       acc_exok_q;

   logic [IdWidth-1:0]         wr_id_q;
   logic [WideDataWidth-1:0]   wr_data_q;
   logic [1:0]                 wr_resp_q;
   logic                       wr_last_q;
   logic [UserWidth-1:0]       wr_user_q;
   logic                       wr_valid_q;
   logic                       proto_err_q;

   logic [AddrWidth-1:0]       step_c;
   logic                       nr_hs_c;
   logic                       final_c;
   logic                       cross_c;
   logic                       emit_c;
   logic                       mismatch_c;
   int unsigned                lane_lo_c;
   int unsigned                lane_hi_c;
   logic [WideDataWidth-1:0]   merged_data_c;
   logic [1:0]                 merged_err_c;
   logic                       merged_exok_c;
   logic [1:0]                 merged_resp_c;

   assign cmd_ready_o = (state_q == StIdle);
   assign nr_ready_o  = (state_q == StPack) && (!wr_valid_q || wr_ready_i);

   assign step_c     = AddrWidth'(1) << size_q;
   assign nr_hs_c    = nr_valid_i && nr_ready_o;
   assign final_c    = nr_last_i || (rem_q == 8'd0);
   assign mismatch_c = nr_last_i != (rem_q == 8'd0);
   assign cross_c    = (addr_q + step_c) == '0;
   assign emit_c     = nr_hs_c && (cross_c || final_c);

   // Narrow lane of a byte equals its wide lane mod NarrowBytes, so copy lane-for-lane.
   always_comb begin
      lane_lo_c     = 32'(addr_q);
      lane_hi_c     = 32'(addr_q) + 32'(step_c);
      merged_data_c = acc_data_q;
      for (int unsigned w = 0; w < WideBytes; w++) begin
         if ((w >= lane_lo_c) && (w < lane_hi_c)) begin
            merged_data_c[8*w +: 8] = nr_data_i[8*(w % NarrowBytes) +: 8];
         end
      end
   end

   // Worst error wins; EXOKAY survives only if every contributing beat was EXOKAY.
   always_comb begin
      merged_err_c  = acc_err_q;
      if (nr_resp_i[1] && (nr_resp_i > acc_err_q)) begin
         merged_err_c = nr_resp_i;
      end
      merged_exok_c = acc_exok_q && (nr_resp_i == 2'b01);
      merged_resp_c = (merged_err_c != 2'b00) ? merged_err_c : {1'b0, merged_exok_c};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         id_q        <= '0;
         addr_q      <= '0;
         size_q      <= '0;
         rem_q       <= '0;
         acc_data_q  <= '0;
         acc_err_q   <= '0;
         acc_exok_q  <= 1'b1;
         wr_id_q     <= '0;
         wr_data_q   <= '0;
         wr_resp_q   <= '0;
         wr_last_q   <= 1'b0;
         wr_user_q   <= '0;
         wr_valid_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= 1'b0;
         if (wr_valid_q && wr_ready_i) begin
            wr_valid_q <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (cmd_valid_i) begin
                  id_q       <= cmd_id_i;
                  addr_q     <= cmd_offset_i;
                  size_q     <= cmd_size_i;
                  rem_q      <= cmd_len_i;
                  acc_data_q <= '0;
                  acc_err_q  <= '0;
                  acc_exok_q <= 1'b1;
                  state_q    <= StPack;
               end
            end
            StPack: begin
               if (nr_hs_c) begin
                  addr_q <= addr_q + step_c;
                  rem_q  <= rem_q - 8'd1;
                  if (emit_c) begin
                     wr_id_q    <= id_q;
                     wr_data_q  <= merged_data_c;
                     wr_resp_q  <= merged_resp_c;
                     wr_last_q  <= final_c;
                     wr_user_q  <= nr_user_i;
                     wr_valid_q <= 1'b1;
                     acc_data_q <= '0;
                     acc_err_q  <= '0;
                     acc_exok_q <= 1'b1;
                  end else begin
                     acc_data_q <= merged_data_c;
                     acc_err_q  <= merged_err_c;
                     acc_exok_q <= merged_exok_c;
                  end
                  if (final_c) begin
                     proto_err_q <= mismatch_c;
                     state_q     <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign wr_id_o     = wr_id_q;
   assign wr_data_o   = wr_data_q;
   assign wr_resp_o   = wr_resp_q;
   assign wr_last_o   = wr_last_q;
   assign wr_user_o   = wr_user_q;
   assign wr_valid_o  = wr_valid_q;
   assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_axi_r_upsize_packer.sv
// Directed bench for axi_r_upsize_packer at 32->64 bits; wide beats are scoreboarded.
module tb_axi_r_upsize_packer;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_id;
   logic [2:0]  cmd_offset;
   logic [2:0]  cmd_size;
   logic [7:0]  cmd_len;
   logic [31:0] nr_data;
   logic [1:0]  nr_resp;
   logic        nr_last;
   logic [7:0]  nr_user;
   logic        nr_valid;
   logic        nr_ready;
   logic [3:0]  wr_id;
   logic [63:0] wr_data;
   logic [1:0]  wr_resp;
   logic        wr_last;
   logic [7:0]  wr_user;
   logic        wr_valid;
   logic        wr_ready;
   logic        proto_err;

   int n_tests;
   int n_failed;

   logic [78:0] got_q[$];
   logic [78:0] exp_q[$];

   axi_r_upsize_packer #(
      .NarrowDataWidth(32),
      .WideDataWidth  (64),
      .IdWidth        (4),
      .UserWidth      (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_id_i    (cmd_id),
      .cmd_offset_i(cmd_offset),
      .cmd_size_i  (cmd_size),
      .cmd_len_i   (cmd_len),
      .nr_data_i   (nr_data),
      .nr_resp_i   (nr_resp),
      .nr_last_i   (nr_last),
      .nr_user_i   (nr_user),
      .nr_valid_i  (nr_valid),
      .nr_ready_o  (nr_ready),
      .wr_id_o     (wr_id),
      .wr_data_o   (wr_data),
      .wr_resp_o   (wr_resp),
      .wr_last_o   (wr_last),
      .wr_user_o   (wr_user),
      .wr_valid_o  (wr_valid),
      .wr_ready_i  (wr_ready),
      .proto_err_o (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every wide handshake; inputs change only just after posedge.
   always @(negedge clk) begin
      if (rst_n && wr_valid && wr_ready) begin
         got_q.push_back({wr_id, wr_data, wr_resp, wr_last, wr_user});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [78:0] mk(input logic [3:0] id, input logic [63:0] d,
                                      input logic [1:0] r, input logic l, input logic [7:0] u);
      return {id, d, r, l, u};
   endfunction

   task automatic send_cmd(input logic [3:0] id, input logic [2:0] off,
                           input logic [2:0] size, input logic [7:0] len);
      int n;
      cmd_valid = 1'b1; cmd_id = id; cmd_offset = off; cmd_size = size; cmd_len = len;
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
      if (!cmd_ready) check("cmd_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_nr(input logic [31:0] d, input logic [1:0] r, input logic l,
                          input logic [7:0] u);
      int n;
      nr_valid = 1'b1; nr_data = d; nr_resp = r; nr_last = l; nr_user = u;
      n = 0;
      do begin @(negedge clk); n++; end while (!nr_ready && n < 100);
      if (!nr_ready) check("nr_timeout", 0, 1);
      @(posedge clk); #1;
      nr_valid = 1'b0;
   endtask

   task automatic compare_beats(input string tag);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_beat%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [63:0] held;
      logic [31:0] bd;
      n_tests = 0; n_failed = 0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_offset = '0; cmd_size = '0;
      cmd_len = '0; nr_data = '0; nr_resp = '0; nr_last = 1'b0; nr_user = '0;
      nr_valid = 1'b0; wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_nr_ready", nr_ready, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_proto_err", proto_err, 0);
      check("rst_wr_data", wr_data, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Aligned 4-beat burst, two wide beats, 1-cycle latency
      send_cmd(4'd3, 3'd0, 3'd2, 8'd3);
      send_nr(32'hA0A0A0A0, 2'b00, 1'b0, 8'd1);
      check("t1_no_emit_after_b0", wr_valid, 0);
      send_nr(32'hB1B1B1B1, 2'b00, 1'b0, 8'd2);
      check("t1_latency_valid", wr_valid, 1);
      check("t1_latency_data", wr_data, 64'hB1B1B1B1_A0A0A0A0);
      send_nr(32'hC2C2C2C2, 2'b00, 1'b0, 8'd3);
      send_nr(32'hD3D3D3D3, 2'b00, 1'b1, 8'd4);
      check("t1_last_valid", wr_valid, 1);
      check("t1_last_flag", wr_last, 1);
      exp_q.push_back(mk(4'd3, 64'hB1B1B1B1_A0A0A0A0, 2'b00, 1'b0, 8'd2));
      exp_q.push_back(mk(4'd3, 64'hD3D3D3D3_C2C2C2C2, 2'b00, 1'b1, 8'd4));
      compare_beats("t1");

      // Start in upper half: each narrow beat is its own wide beat
      send_cmd(4'd5, 3'd4, 3'd2, 8'd1);
      send_nr(32'h11111111, 2'b00, 1'b0, 8'h10);
      send_nr(32'h22222222, 2'b00, 1'b1, 8'h20);
      exp_q.push_back(mk(4'd5, 64'h11111111_00000000, 2'b00, 1'b0, 8'h10));
      exp_q.push_back(mk(4'd5, 64'h00000000_22222222, 2'b00, 1'b1, 8'h20));
      compare_beats("t2");

      // Byte beats from offset 1; off-lane garbage must not leak
      send_cmd(4'd7, 3'd1, 3'd0, 8'd2);
      send_nr(32'h1234AA56, 2'b00, 1'b0, 8'h01);
      send_nr(32'h77BB8899, 2'b00, 1'b0, 8'h02);
      send_nr(32'hCCDDEEFF, 2'b00, 1'b1, 8'h03);
      exp_q.push_back(mk(4'd7, 64'h00000000_CCBBAA00, 2'b00, 1'b1, 8'h03));
      compare_beats("t3");

      // Response merge
      send_cmd(4'd1, 3'd0, 3'd2, 8'd1);
      send_nr(32'h1, 2'b00, 1'b0, 8'd0);
      send_nr(32'h2, 2'b10, 1'b1, 8'd0);
      exp_q.push_back(mk(4'd1, 64'h00000002_00000001, 2'b10, 1'b1, 8'd0));
      send_cmd(4'd1, 3'd0, 3'd2, 8'd1);
      send_nr(32'h3, 2'b01, 1'b0, 8'd0);
      send_nr(32'h4, 2'b01, 1'b1, 8'd0);
      exp_q.push_back(mk(4'd1, 64'h00000004_00000003, 2'b01, 1'b1, 8'd0));
      send_cmd(4'd1, 3'd0, 3'd2, 8'd1);
      send_nr(32'h5, 2'b01, 1'b0, 8'd0);
      send_nr(32'h6, 2'b00, 1'b1, 8'd0);
      exp_q.push_back(mk(4'd1, 64'h00000006_00000005, 2'b00, 1'b1, 8'd0));
      send_cmd(4'd1, 3'd0, 3'd2, 8'd1);
      send_nr(32'h7, 2'b11, 1'b0, 8'd0);
      send_nr(32'h8, 2'b10, 1'b1, 8'd0);
      exp_q.push_back(mk(4'd1, 64'h00000008_00000007, 2'b11, 1'b1, 8'd0));
      compare_beats("t4");

      // Backpressure on the wide side during an 8-beat burst
      wr_ready = 1'b0;
      send_cmd(4'd9, 3'd0, 3'd2, 8'd7);
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               bd = {4{8'(8'h40 + k)}};
               send_nr(bd, 2'b00, (k == 7), 8'(k));
            end
         end
         begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!wr_valid && n < 100);
            held = wr_data;
            repeat (5) @(negedge clk);
            check("t5_nr_ready_blocked", nr_ready, 0);
            check("t5_held_valid", wr_valid, 1);
            check("t5_held_stable", wr_data, held);
            @(posedge clk); #1;
            wr_ready = 1'b1;
         end
      join
      exp_q.push_back(mk(4'd9, 64'h41414141_40404040, 2'b00, 1'b0, 8'd1));
      exp_q.push_back(mk(4'd9, 64'h43434343_42424242, 2'b00, 1'b0, 8'd3));
      exp_q.push_back(mk(4'd9, 64'h45454545_44444444, 2'b00, 1'b0, 8'd5));
      exp_q.push_back(mk(4'd9, 64'h47474747_46464646, 2'b00, 1'b1, 8'd7));
      compare_beats("t5");

      // Early last: nr_last on beat 2 of a len-3 burst
      send_cmd(4'd2, 3'd0, 3'd2, 8'd3);
      send_nr(32'hE0E0E0E0, 2'b00, 1'b0, 8'd0);
      send_nr(32'hE1E1E1E1, 2'b00, 1'b0, 8'd1);
      send_nr(32'hE2E2E2E2, 2'b00, 1'b1, 8'd2);
      check("t6_proto_err_pulse", proto_err, 1);
      check("t6_cmd_ready", cmd_ready, 1);
      check("t6_last", wr_last, 1);
      @(posedge clk); #1;
      check("t6_proto_err_drop", proto_err, 0);
      exp_q.push_back(mk(4'd2, 64'hE1E1E1E1_E0E0E0E0, 2'b00, 1'b0, 8'd1));
      exp_q.push_back(mk(4'd2, 64'h00000000_E2E2E2E2, 2'b00, 1'b1, 8'd2));
      compare_beats("t6");

      // Missing last: len 0 but nr_last low
      send_cmd(4'd4, 3'd0, 3'd2, 8'd0);
      send_nr(32'h0BADF00D, 2'b00, 1'b0, 8'h55);
      check("t7_proto_err_pulse", proto_err, 1);
      exp_q.push_back(mk(4'd4, 64'h00000000_0BADF00D, 2'b00, 1'b1, 8'h55));
      compare_beats("t7");

      // Reset mid-burst with a held wide beat
      wr_ready = 1'b0;
      send_cmd(4'd6, 3'd0, 3'd2, 8'd3);
      send_nr(32'h99999999, 2'b00, 1'b0, 8'd0);
      send_nr(32'h88888888, 2'b00, 1'b0, 8'd0);
      check("t8_held_before_rst", wr_valid, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t8_rst_wr_valid", wr_valid, 0);
      check("t8_rst_cmd_ready", cmd_ready, 1);
      check("t8_rst_nr_ready", nr_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wr_ready = 1'b1;
      send_cmd(4'd8, 3'd0, 3'd2, 8'd0);
      send_nr(32'h12345678, 2'b01, 1'b1, 8'h77);
      exp_q.push_back(mk(4'd8, 64'h00000000_12345678, 2'b01, 1'b1, 8'h77));
      compare_beats("t8");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule

// File: doc/axi_r_upsize_packer.md
Name: axi_r_upsize_packer

Overview:
- Return-path stage on the read side of the data-width downsizer; sits between the narrow master port and the wide slave port.
- Packs narrow R beats from the narrow slave into wide R beats for the wide master.
- Driven by one command per read burst, supplied by the AR-splitting logic: ID, start lane offset, size, narrow beat count.
- INCR bursts only; FIXED/WRAP splitting is resolved upstream.

Parameters:
- NarrowDataWidth, 32, narrow R data width in bits; power of 2, >= 8.
- WideDataWidth, 64, wide R data width in bits; power of 2, > NarrowDataWidth.
- IdWidth, 4, AXI ID width.
- UserWidth, 8, AXI user width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  burst command ready.
- cmd_id_i  in  IdWidth  ID returned on the wide beats.
- cmd_offset_i  in  log2(WideDataWidth/8)  start address mod wide bytes.
- cmd_size_i  in  3  AxSIZE; <= log2(NarrowDataWidth/8).
- cmd_len_i  in  8  narrow beats minus 1.
- nr_data_i  in  NarrowDataWidth  narrow R data.
- nr_resp_i  in  2  narrow R response.
- nr_last_i  in  1  narrow R last.
- nr_user_i  in  UserWidth  narrow R user.
- nr_valid_i  in  1  narrow R valid.
- nr_ready_o  out  1  narrow R ready.
- wr_id_o  out  IdWidth  wide R ID.
- wr_data_o  out  WideDataWidth  wide R data.
- wr_resp_o  out  2  wide R response.
- wr_last_o  out  1  wide R last.
- wr_user_o  out  UserWidth  wide R user; taken from the last contributing narrow beat.
- wr_valid_o  out  1  wide R valid.
- wr_ready_i  in  1  wide R ready.
- proto_err_o  out  1  one-cycle pulse on narrow last mismatch.

Behaviour:
- Reset values: state IDLE; all outputs 0 except cmd_ready_o=1; accumulators cleared.
- Reset mid-burst: partial data is discarded and nothing is emitted.
- Clocking and reset: single clock; reset is asynchronous and active-low.
- State IDLE:
  - cmd_ready_o=1, nr_ready_o=0.
  - On command handshake: latch ID, addr = offset, size, remaining = len; go to PACK.
  - A command may be accepted while the previous burst's final wide beat is still held on the output.
- State PACK:
  - cmd_ready_o=0.
  - nr_ready_o = !wr_valid_o | wr_ready_i.
- Per narrow handshake:
  - Copy the 2^size bytes at byte lanes addr mod (NarrowDataWidth/8) of nr_data_i into wide byte lanes addr mod (WideDataWidth/8) of the accumulator.
  - Merge resp into the accumulator (see response merge below).
  - addr += 2^size; remaining -= 1.
- Wide beat emission:
  - Emit when the accepted narrow beat crosses a wide boundary ((addr + 2^size) mod WideBytes == 0) or is the final beat (remaining == 0).
  - The accumulator is loaded into the output register: latency is 1 cycle from the narrow handshake to wr_valid_o=1.
  - The accumulator is cleared in the same cycle; byte lanes not written in a wide beat read 0.
- Output handshake:
  - wr_valid_o stays high with stable payload until wr_ready_i.
  - A narrow beat may be accepted in the same cycle the held wide beat is taken (full throughput, no bubble).
- wr_last_o=1 only on the wide beat containing the final narrow beat; after that beat's narrow handshake, return to IDLE.
- Response merge per wide beat:
  - If any beat has resp[1]=1, output the numerically largest such resp (DECERR 3 > SLVERR 2).
  - Otherwise output EXOKAY only if all contributing beats were EXOKAY, else OKAY.
- Narrow ID is not checked; wr_id_o = latched cmd ID.
- Last mismatch:
  - nr_last_i=1 with remaining != 0: treat the beat as final (emit wide beat with last=1, go to IDLE) and pulse proto_err_o.
  - nr_last_i=0 with remaining == 0: same completion, and pulse proto_err_o.

Test Plan:
- Parameters 32/64. Cmd offset 0, size 2, len 3; narrow data A0A0A0A0, B1B1B1B1, C2C2C2C2, D3D3D3D3 -> two wide beats: B1B1B1B1_A0A0A0A0 (last=0), then D3D3D3D3_C2C2C2C2 (last=1); each valid 1 cycle after its completing narrow beat.
- Cmd offset 4, size 2, len 1; data 11111111, 22222222 -> wide 11111111_00000000 (last=0), then 00000000_22222222 (last=1).
- Cmd offset 1, size 0, len 2; data xxxxAAxx, xxBBxxxx, CCxxxxxx -> single wide beat 00000000_CCBBAA00, last=1.
- Cmd len 1, resps OKAY then SLVERR -> wide resp 2; all EXOKAY -> resp 1; EXOKAY then OKAY -> resp 0.
- Hold wr_ready_i=0 for 5 cycles during a len-7 burst -> nr_ready_o low while output full, no beat lost or duplicated, order preserved.
- Cmd len 3, nr_last_i=1 on narrow beat 2 -> wide last=1 after beat 2, proto_err_o pulses 1 cycle, cmd_ready_o=1 next cycle; rst_ni low mid-burst -> wr_valid_o=0 and state IDLE immediately.
